// File: rtl/gauss_window_feeder.sv
// Raster-to-3x3 window feeder for a handshaked neighbourhood filter.
// Presents one window at a time, waits for done_i (bounded by TIMEOUT) and returns the result tagged with its centre.
module gauss_window_feeder #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk_i_f,
    input  logic       rst_i_f,
    input  logic [7:0] pix_i,
    input  logic       pix_valid_i,
    output logic       pix_ready_o,
    output logic       en_o,
    output logic [7:0] win_0_o,
    output logic [7:0] win_1_o,
    output logic [7:0] win_2_o,
    output logic [7:0] win_3_o,
    output logic [7:0] win_4_o,
    output logic [7:0] win_5_o,
    output logic [7:0] win_6_o,
    output logic [7:0] win_7_o,
    output logic [7:0] win_8_o,
    input  logic       done_i,
    input  logic [7:0] data_i,
    output logic [7:0] res_o,
    output logic       res_valid_o,
    output logic [7:0] res_x_o,
    output logic [7:0] res_y_o,
    output logic       frame_done_o,
    output logic       err_o
);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(IMG_W);

    logic [1:0]    state;
    logic [7:0]    col;
    logic [7:0]    row;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] ci;
    logic          acc;

    logic [7:0]    ctr_x_p0;
    logic [7:0]    ctr_y_p0;
    logic          last_p0;

    logic [7:0]    win_p0 [9];
    logic [7:0]    lb_old [IMG_W];
    logic [7:0]    lb_new [IMG_W];

    // Reset must silence the handshake immediately, even though state is already FILL.
    assign pix_ready_o = (state == FILL) && !rst_i_f;
    assign en_o        = (state == ISSUE);
    assign acc         = pix_ready_o && pix_valid_i;
    assign ci          = col[AW-1:0];

    assign win_0_o = win_p0[0];
    assign win_1_o = win_p0[1];
    assign win_2_o = win_p0[2];
    assign win_3_o = win_p0[3];
    assign win_4_o = win_p0[4];
    assign win_5_o = win_p0[5];
    assign win_6_o = win_p0[6];
    assign win_7_o = win_p0[7];
    assign win_8_o = win_p0[8];

    // Line buffers carry no reset; windows only issue once two full rows of this frame are stored.
    always_ff @(posedge clk_i_f) begin
        if (acc) begin
            lb_old[ci] <= lb_new[ci];
            lb_new[ci] <= pix_i;
        end
    end

    // Stage p0: window shift register, new column enters on the right.
    always_ff @(posedge clk_i_f or posedge rst_i_f) begin
        if (rst_i_f) begin
            for (int k = 0; k < 9; k++) win_p0[k] <= 8'd0;
        end else if (acc) begin
            win_p0[0] <= win_p0[1];
            win_p0[1] <= win_p0[2];
            win_p0[2] <= lb_old[ci];
            win_p0[3] <= win_p0[4];
            win_p0[4] <= win_p0[5];
            win_p0[5] <= lb_new[ci];
            win_p0[6] <= win_p0[7];
            win_p0[7] <= win_p0[8];
            win_p0[8] <= pix_i;
        end
    end

    always_ff @(posedge clk_i_f or posedge rst_i_f) begin
        if (rst_i_f) begin
            state        <= FILL;
            col          <= 8'd0;
            row          <= 8'd0;
            wait_cnt     <= '0;
            ctr_x_p0     <= 8'd0;
            ctr_y_p0     <= 8'd0;
            last_p0      <= 1'b0;
            res_o        <= 8'd0;
            res_x_o      <= 8'd0;
            res_y_o      <= 8'd0;
            res_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            res_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                FILL: begin
                    if (acc) begin
                        if (col == 8'(IMG_W - 1)) begin
                            col <= 8'd0;
                            row <= (row == 8'(IMG_H - 1)) ? 8'd0 : row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                        if (row >= 8'd2 && col >= 8'd2) begin
                            state    <= ISSUE;
                            wait_cnt <= '0;
                            ctr_x_p0 <= col - 8'd1;
                            ctr_y_p0 <= row - 8'd1;
                            last_p0  <= (row == 8'(IMG_H - 1)) && (col == 8'(IMG_W - 1));
                        end
                    end
                end
                // Stage p1: hold the window until the filter answers or the wait budget runs out.
                ISSUE: begin
                    if (done_i) begin
                        res_o        <= data_i;
                        res_x_o      <= ctr_x_p0;
                        res_y_o      <= ctr_y_p0;
                        res_valid_o  <= 1'b1;
                        frame_done_o <= last_p0;
                        state        <= GAP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        err_o        <= 1'b1;
                        frame_done_o <= last_p0;
                        state        <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                GAP:     state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_window_feeder.sv
// Randomized bench for gauss_window_feeder: image-level reference model, filter responder and per-cycle checker.
module tb_gauss_window_feeder;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pix = 8'd0;
    logic       pv = 1'b0;
    logic       done = 1'b0;
    logic [7:0] data = 8'd0;
    wire        ready, en, rv, fd, err;
    wire  [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8, res, rx, ry;

    always #5 clk = ~clk;

    gauss_window_feeder #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
        .clk_i_f(clk), .rst_i_f(rst), .pix_i(pix), .pix_valid_i(pv), .pix_ready_o(ready),
        .en_o(en), .win_0_o(w0), .win_1_o(w1), .win_2_o(w2), .win_3_o(w3), .win_4_o(w4),
        .win_5_o(w5), .win_6_o(w6), .win_7_o(w7), .win_8_o(w8), .done_i(done), .data_i(data),
        .res_o(res), .res_valid_o(rv), .res_x_o(rx), .res_y_o(ry), .frame_done_o(fd), .err_o(err)
    );

    logic [7:0] wdut [9];
    assign wdut[0] = w0; assign wdut[1] = w1; assign wdut[2] = w2;
    assign wdut[3] = w3; assign wdut[4] = w4; assign wdut[5] = w5;
    assign wdut[6] = w6; assign wdut[7] = w7; assign wdut[8] = w8;

    typedef struct {
        logic [8:0][7:0] win;
        int x; int y; bit last; bit has_res; int res; int len;
    } exp_t;
    typedef struct { int res; int x; int y; bit fd; } log_t;

    int nchk = 0, nerr = 0;
    int lat = 5, mode = 0, res_seen = 0;
    bit spur = 0, abort_drv = 0;
    int img [H][W];
    int br = 0, bc = 0;
    exp_t wq[$];
    exp_t cur;
    bit   cur_ok = 0;
    log_t lg[$];

    task automatic chk(string nm, int act, int req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic int gauss9(logic [8:0][7:0] v);
        int s;
        s = v[0] + 2*v[1] + v[2] + 2*v[3] + 4*v[4] + 2*v[5] + v[6] + 2*v[7] + v[8];
        return s / 16;
    endfunction

    function automatic int filt(logic [8:0][7:0] v);
        return (mode == 0) ? int'(v[4]) : gauss9(v);
    endfunction

    // Reference: keep the image, derive every complete window and its expected outcome.
    task automatic record(int v);
        exp_t e;
        img[br][bc] = v;
        if (br >= 2 && bc >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[r*3+c] = 8'(img[br-2+r][bc-2+c]);
            e.x = bc - 1;
            e.y = br - 1;
            e.last = (br == H-1) && (bc == W-1);
            e.has_res = (lat <= TO);
            e.res = filt(e.win);
            e.len = (lat < TO) ? lat : TO;
            wq.push_back(e);
        end
        if (bc == W-1) begin
            bc = 0;
            br = (br == H-1) ? 0 : br + 1;
        end else bc++;
    endtask

    task automatic send_frame(int kind, int prob);
        int i = 0, budget = 0, v;
        while (i < W*H && !abort_drv && budget <= 20000) begin
            @(negedge clk);
            v = (kind == 0) ? i : (kind == 1) ? int'($urandom_range(255)) : 100;
            pv = ($urandom_range(99) < prob);
            pix = 8'(v);
            if (pv && ready) begin
                record(v);
                i++;
            end
            budget++;
        end
        if (budget > 20000) chk("drv_budget", i, W*H);
        @(negedge clk);
        pv = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || en || !ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", n, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        logic [8:0][7:0] d;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) d[k] = wdut[k];
        chk("rst_en", en, 0);
        chk("rst_ready", ready, 0);
        chk("rst_res_valid", rv, 0);
        chk("rst_frame_done", fd, 0);
        chk("rst_err", err, 0);
        chk("rst_res", res, 0);
        chk("rst_res_x", rx, 0);
        chk("rst_res_y", ry, 0);
        nchk++;
        if (d !== '0) begin
            nerr++;
            $display("FAIL rst_window: got %h expected 0", d);
        end
        wq.delete();
        br = 0; bc = 0; pv = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", ready, 1);
    endtask

    // Hand-computed outcome for a 4x4 frame of pixels 0..15 with the centre-returning filter.
    task automatic check_lit(string tag);
        int er[4] = '{5, 6, 9, 10};
        int ex[4] = '{1, 2, 1, 2};
        int ey[4] = '{1, 1, 2, 2};
        int ef[4] = '{0, 0, 0, 1};
        chk({tag, "_count"}, lg.size(), 4);
        if (lg.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk({tag, "_res"}, lg[k].res, er[k]);
                chk({tag, "_x"}, lg[k].x, ex[k]);
                chk({tag, "_y"}, lg[k].y, ey[k]);
                chk({tag, "_fd"}, int'(lg[k].fd), ef[k]);
            end
        end
    endtask

    // Filter stand-in: answers after lat enabled cycles, or drives spur outside a window.
    int ecnt = 0;
    always @(negedge clk) begin
        logic [8:0][7:0] d;
        if (rst) begin
            ecnt = 0;
            done = 1'b0;
        end else if (en) begin
            ecnt++;
            for (int k = 0; k < 9; k++) d[k] = wdut[k];
            done = (ecnt == lat);
            data = 8'(filt(d));
        end else begin
            ecnt = 0;
            done = spur;
            data = 8'hEE;
        end
    end

    bit en_prev = 0, gap_prev = 0;
    int en_cnt = 0;
    always @(negedge clk) begin
        logic [8:0][7:0] d;
        if (rst) begin
            en_prev = 0; gap_prev = 0; en_cnt = 0; cur_ok = 0;
        end else begin
            if (en && !en_prev) begin
                en_cnt = 0;
                if (wq.size() == 0) begin
                    chk("unexpected_window", 1, 0);
                    cur_ok = 0;
                end else begin
                    cur = wq.pop_front();
                    cur_ok = 1;
                end
            end
            if (en) begin
                en_cnt++;
                chk("ready_in_issue", ready, 0);
                if (cur_ok) begin
                    for (int k = 0; k < 9; k++) d[k] = wdut[k];
                    nchk++;
                    if (d !== cur.win) begin
                        nerr++;
                        $display("FAIL window (%0d,%0d): got %h expected %h", cur.y, cur.x, d, cur.win);
                    end
                end
            end
            if (en_prev && !en) begin
                chk("ready_in_gap", ready, 0);
                if (cur_ok) begin
                    chk("en_length", en_cnt, cur.len);
                    chk("res_valid", rv, int'(cur.has_res));
                    chk("frame_done", fd, int'(cur.last));
                    if (cur.has_res && rv) begin
                        chk("res", res, cur.res);
                        chk("res_x", rx, cur.x);
                        chk("res_y", ry, cur.y);
                    end
                end
                cur_ok = 0;
            end else begin
                chk("res_valid_idle", rv, 0);
                chk("frame_done_idle", fd, 0);
            end
            if (gap_prev) begin
                chk("fill_after_gap", ready, 1);
                chk("en_after_gap", en, 0);
            end
            if (rv) begin
                lg.push_back('{int'(res), int'(rx), int'(ry), fd});
                res_seen++;
            end
            gap_prev = en_prev && !en;
            en_prev = en;
        end
    end

    initial begin
        int n, rs;
        do_reset();

        mode = 0; lat = 37; lg.delete();
        send_frame(0, 100); drain(); check_lit("ramp");

        lat = $urandom_range(1, 10); lg.delete();
        send_frame(0, 50); drain(); check_lit("ramp_gappy");

        rs = res_seen; spur = 1'b1;
        repeat (10) @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("done_in_fill_ignored", res_seen, rs);
        chk("done_in_fill_err", err, 0);

        mode = 1;
        for (int f = 0; f < 4; f++) begin
            lat = $urandom_range(1, 20);
            send_frame(1, 70); drain();
        end

        lat = 3; lg.delete();
        send_frame(2, 100); drain();
        chk("const_count", lg.size(), 4);
        foreach (lg[k]) chk("const_res", lg[k].res, 100);

        mode = 0; lat = 1000; lg.delete();
        send_frame(0, 100); drain();
        chk("timeout_err", err, 1);
        chk("timeout_no_results", lg.size(), 0);
        lat = 2; lg.delete();
        send_frame(0, 100); drain();
        chk("err_sticky", err, 1);
        check_lit("after_timeout");

        lat = 1000; abort_drv = 1'b0;
        fork send_frame(0, 100); join_none
        n = 0;
        while (!en && n < 400) begin @(negedge clk); n++; end
        chk("issue_reached", en, 1);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_drops_en", en, 0);
        abort_drv = 1'b1;
        repeat (3) @(negedge clk);
        abort_drv = 1'b0;
        do_reset();

        mode = 0; lat = 10; lg.delete();
        send_frame(0, 100); drain(); check_lit("post_reset");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
